uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each completed byte presented on the receiver's done strobe, stores it in a circular buffer, and hands bytes to the host-side consumer through a registered read port. A full buffer either back-pressures the receiver through its write-hold input or drops the byte and raises a sticky overflow flag; the `UART_RX_FIFO_HOLD_EN` macro selects which.

---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer between the UART receiver and the host consumer.
// Define UART_RX_FIFO_HOLD_EN to back-pressure the receiver when full; otherwise bytes are dropped and overflow is set.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       wr_strobe,
  output logic                       wr_hold,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_acc_s, rd_acc_s, ovf_set_s;
  logic                  empty_s, full_s;

  // Flags are decoded from the registered count only, so a same-cycle pop never frees a slot.
  assign empty_s  = (count_q == {CW{1'b0}});
  assign full_s   = (count_q == CW'(DEPTH));
  assign wr_acc_s = wr_strobe & ~full_s;
  assign rd_acc_s = rd_en & ~empty_s;

`ifdef UART_RX_FIFO_HOLD_EN
  assign ovf_set_s = 1'b0;
  assign wr_hold   = full_s;
`else
  assign ovf_set_s = wr_strobe & full_s;
  assign wr_hold   = 1'b0;
`endif

  // Next-state computation for pointers, count, read port and overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      rd_valid_d = 1'b0;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Set has priority over clear.
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      rd_data_q  <= {DATA_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign overflow    = overflow_q;
  assign count       = count_q;
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (count_q >= CW'(AF_LEVEL));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: vector table plus hand-written corner sequences.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       wr_hold;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .wr_hold(wr_hold), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .almost_full(almost_full), .count(count),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       emp;
    logic       rv;
    logic [7:0] rdat;
    logic       ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_strobe = 1'b0;
    wr_data   = 8'h00;
    rd_en     = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  initial begin
    // Test 1 and same-cycle read/write cases: expected state after each edge.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'h3C, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h3C, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h3C, 1'b0};
    vecs[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h3C, 1'b0};
    vecs[7]  = '{1'b1, 8'h9E, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'h9E, 1'b0};
    vecs[9]  = '{1'b1, 8'h42, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h9E, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'h42, 1'b0};

    idle_inputs();
    reset = 1'b1;
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_hold", int'(wr_hold), 0);
    chk("rst_rdata", int'(rd_data), 0);
    chk("rst_rvalid", int'(rd_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      wr_strobe = vecs[i].wr;
      wr_data   = vecs[i].wd;
      rd_en     = vecs[i].rd;
      ovf_clr   = vecs[i].clr;
      step();
      chk($sformatf("v%0d_count", i), int'(count), vecs[i].cnt);
      chk($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].emp));
      chk($sformatf("v%0d_rvalid", i), int'(rd_valid), int'(vecs[i].rv));
      chk($sformatf("v%0d_rdata", i), int'(rd_data), int'(vecs[i].rdat));
      chk($sformatf("v%0d_ovf", i), int'(overflow), int'(vecs[i].ovf));
    end
    idle_inputs();

    // Fill with 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      wr_strobe = 1'b1;
      wr_data   = 8'(i);
      step();
      chk($sformatf("fill%0d_count", i), int'(count), i + 1);
      chk($sformatf("fill%0d_af", i), int'(almost_full), (i + 1 >= 12) ? 1 : 0);
      chk($sformatf("fill%0d_full", i), int'(full), (i + 1 == 16) ? 1 : 0);
    end

`ifdef UART_RX_FIFO_HOLD_EN
    wr_data = 8'h77;
    step();
    chk("hold_count", int'(count), 16);
    chk("hold_hold", int'(wr_hold), 1);
    chk("hold_ovf", int'(overflow), 0);
    rd_en = 1'b1;
    step();
    chk("hold_pop_data", int'(rd_data), 8'h00);
    chk("hold_pop_count", int'(count), 15);
    chk("hold_release", int'(wr_hold), 0);
    rd_en = 1'b0;
    step();
    chk("hold_wr_count", int'(count), 16);
    chk("hold_wr_ovf", int'(overflow), 0);
    idle_inputs();
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("drain%0d_rv", i), int'(rd_valid), 1);
      chk($sformatf("drain%0d_data", i), int'(rd_data), (i == 15) ? 8'h77 : i + 1);
    end
`else
    wr_data = 8'h55;
    step();
    chk("drop_count", int'(count), 16);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_hold", int'(wr_hold), 0);
    wr_data = 8'h66;
    ovf_clr = 1'b1;
    step();
    chk("setclr_ovf", int'(overflow), 1);
    chk("setclr_count", int'(count), 16);
    wr_strobe = 1'b0;
    step();
    chk("clr_ovf", int'(overflow), 0);
    idle_inputs();
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("drain%0d_rv", i), int'(rd_valid), 1);
      chk($sformatf("drain%0d_data", i), int'(rd_data), i);
    end
`endif
    idle_inputs();
    step();
    chk("drained_count", int'(count), 0);
    chk("drained_empty", int'(empty), 1);
    chk("drained_rv", int'(rd_valid), 0);

    // Asynchronous reset at count=5 with rd_valid high.
    for (int i = 0; i < 6; i++) begin
      wr_strobe = 1'b1;
      wr_data   = 8'hA0 + 8'(i);
      step();
    end
    idle_inputs();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pre_rst_count", int'(count), 5);
    chk("pre_rst_rv", int'(rd_valid), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_empty", int'(empty), 1);
    chk("arst_count", int'(count), 0);
    chk("arst_rv", int'(rd_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    wr_strobe = 1'b1;
    wr_data   = 8'hC1;
    step();
    wr_data   = 8'hC2;
    step();
    idle_inputs();
    rd_en = 1'b1;
    step();
    chk("post_rst_d0", int'(rd_data), 8'hC1);
    step();
    chk("post_rst_d1", int'(rd_data), 8'hC2);
    rd_en = 1'b0;
    step();
    chk("post_rst_empty", int'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
